// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core; fetch and data accesses share one req/ready memory port
// Ports: clk_i, rst_i (async, active-low); mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i/mem_ready_i
//        shared memory port; pc_o, state_o, retire_o, halted_o status.
// Option: define MULTI_CYCLE_CPU_MUL_EN to make R-type funct 24 (mul) legal.
module multi_cycle_cpu #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [31:0]       pc_o,
  output logic [2:0]        state_o,
  output logic              retire_o,
  output logic              halted_o
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] rf_q [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, wa;
  logic [31:0] sext, zext, alu_res, mul_res, wd;
  logic is_r, is_br, is_ls, legal, retire, wr_en, unused_ok;
`ifdef MULTI_CYCLE_CPU_MUL_EN
  localparam logic MUL_EN = 1'b1;
  assign mul_res = a_q * b_q;
`else
  localparam logic MUL_EN = 1'b0;
  assign mul_res = '0;
`endif
  assign op    = ir_q[31:26];
  assign fn    = ir_q[5:0];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext  = {16'h0, ir_q[15:0]};
  assign is_r  = op == 6'd0;
  assign is_br = op == 6'd4 || op == 6'd5;
  assign is_ls = op == 6'd35 || op == 6'd43;
  assign wa    = is_r ? ir_q[15:11] : rt;
  assign wd    = op == 6'd35 ? mdr_q : alu_q;
  assign unused_ok = ^ir_q[10:6];
  assign legal = is_r ? (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42} || (MUL_EN && fn == 6'd24))
                      : (op inside {6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd13, 6'd15, 6'd35, 6'd43});
  always_comb begin
    alu_res = a_q + sext;
    if (is_r)
      case (fn)
        6'd34:   alu_res = a_q - b_q;
        6'd36:   alu_res = a_q & b_q;
        6'd37:   alu_res = a_q | b_q;
        6'd42:   alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
        6'd24:   alu_res = mul_res;
        default: alu_res = a_q + b_q;
      endcase
    else
      case (op)
        6'd10:   alu_res = {31'h0, $signed(a_q) < $signed(sext)};
        6'd13:   alu_res = a_q | zext;
        6'd15:   alu_res = {ir_q[15:0], 16'h0};
        default: alu_res = a_q + sext;
      endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    retire  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      FETCH: if (mem_ready_i) begin
        ir_d    = mem_rdata_i;
        pc_d    = pc_q + 32'd4;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = legal ? EXEC : HALT;
      end
      EXEC: begin
        alu_d = alu_res;
        if (is_br) begin
          // pc_q already points past the branch, so the offset is relative to PC+4
          pc_d    = ((a_q == b_q) == (op == 6'd4)) ? pc_q + {sext[29:0], 2'b00} : pc_q;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (op == 6'd2) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_ls)
          state_d = alu_res[1:0] != 2'b00 ? HALT : MEM;
        else
          state_d = WB;
      end
      MEM: if (mem_ready_i) begin
        mdr_d   = mem_rdata_i;
        retire  = op == 6'd43;
        state_d = op == 6'd43 ? FETCH : WB;
      end
      WB: begin
        wr_en   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (wr_en && wa != 5'd0) rf_q[wa] <= wd;
    end
  // Status outputs are gated by rst_i so they drop the instant reset asserts
  assign mem_req_o   = rst_i && (state_q == FETCH || state_q == MEM);
  assign mem_we_o    = rst_i && state_q == MEM && op == 6'd43;
  assign mem_addr_o  = state_q == MEM ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
  assign mem_wdata_o = b_q;
  assign pc_o        = pc_q;
  assign state_o     = state_q;
  assign retire_o    = rst_i && retire;
  assign halted_o    = rst_i && state_q == HALT;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: scoreboard bench for multi_cycle_cpu with a wait-state memory responder
module tb_multi_cycle_cpu;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  logic clk_i = 1'b0, rst_i = 1'b0, mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic mem_req_o, mem_we_o, retire_o, halted_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_o;
  logic [2:0] state_o;
  int checks = 0, failures = 0;
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int wait_cfg = 0, wcnt = 0, req_cnt = 0, unstable = 0;
  logic pending = 1'b0, p_we;
  logic [31:0] p_addr, p_wd;
  logic [64:0] obs_dq[$], exp_dq[$];
  logic [31:0] obs_fq[$], exp_fq[$];

  multi_cycle_cpu dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i), .pc_o(pc_o), .state_o(state_o), .retire_o(retire_o),
    .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: instructions from imem, data (state MEM) from dmem, wait_cfg stall cycles per request
  always @(negedge clk_i) begin
    if (!rst_i || !mem_req_o) begin
      mem_ready_i = 1'b0;
      wcnt = 0;
      pending = 1'b0;
    end else begin
      req_cnt++;
      if (pending && (mem_addr_o !== p_addr || mem_we_o !== p_we || mem_wdata_o !== p_wd)) unstable++;
      if (wcnt >= wait_cfg) begin
        mem_ready_i = 1'b1;
        wcnt = 0;
        pending = 1'b0;
        if (state_o == 3'd3) begin
          obs_dq.push_back({mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0});
          if (mem_we_o) dmem[mem_addr_o[9:2]] = mem_wdata_o;
          else mem_rdata_i = dmem[mem_addr_o[9:2]];
        end else begin
          obs_fq.push_back(mem_addr_o);
          mem_rdata_i = imem[mem_addr_o[9:2]];
        end
      end else begin
        mem_ready_i = 1'b0;
        wcnt++;
        pending = 1'b1;
        p_addr = mem_addr_o;
        p_we = mem_we_o;
        p_wd = mem_wdata_o;
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) begin
      imem[i] = HALT_I;
      dmem[i] = '0;
    end
    exp_dq.delete();
    exp_fq.delete();
  endtask

  task automatic do_reset;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    obs_dq.delete();
    obs_fq.delete();
    req_cnt = 0;
    unstable = 0;
    #1 rst_i = 1'b1;
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i);
      #1;
      if (halted_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear_mem();
    wait_cfg = 1000;
    do_reset();
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_pre: req=%b state=%0d expected req=1 state=0", mem_req_o, state_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: got %b expected 0", mem_req_o);
    end
    checks++;
    if ({mem_we_o, retire_o, halted_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: we/retire/halted=%b expected 000", {mem_we_o, retire_o, halted_o});
    end
    checks++;
    if (pc_o !== 32'h0 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: pc=%h state=%0d expected pc=0 state=0", pc_o, state_o);
    end
    wait_cfg = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h state=%0d expected 1/0/0", mem_req_o, mem_addr_o, state_o);
    end
  endtask

  task automatic test_program(input int w);
    int cyc, n;
    bit ok;
    logic [64:0] e, o;
    clear_mem();
    imem[0] = enc_i(8, 0, 1, 5);
    imem[1] = enc_i(8, 0, 2, -3);
    imem[2] = enc_r(1, 2, 3, 32);
    imem[3] = enc_i(43, 0, 3, 16);
    imem[4] = enc_i(35, 0, 4, 16);
    exp_dq.push_back({1'b1, 32'h10, 32'h2});
    exp_dq.push_back({1'b0, 32'h10, 32'h0});
    wait_cfg = w;
    do_reset();
    cyc = 0;
    n = 0;
    while (n < 5 && cyc < 400) begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (retire_o) n++;
    end
    checks++;
    if (n != 5 || cyc != 21 + 7 * w) begin
      failures++;
      $display("FAIL prog_latency w=%0d: retires=%0d cycles=%0d expected 5 retires in %0d", w, n, cyc, 21 + 7 * w);
    end
    wait_halt(100, ok);
    checks++;
    if (!ok || pc_o !== 32'h18) begin
      failures++;
      $display("FAIL prog_halt w=%0d: halted=%b pc=%h expected 1 pc=00000018", w, halted_o, pc_o);
    end
    checks++;
    if (dut.rf_q[1] !== 32'd5 || dut.rf_q[2] !== 32'hFFFF_FFFD || dut.rf_q[3] !== 32'd2) begin
      failures++;
      $display("FAIL prog_regs w=%0d: r1=%h r2=%h r3=%h expected 5/fffffffd/2", w, dut.rf_q[1], dut.rf_q[2], dut.rf_q[3]);
    end
    checks++;
    if (dut.rf_q[4] !== 32'd2) begin
      failures++;
      $display("FAIL prog_lw w=%0d: r4=%h expected 2", w, dut.rf_q[4]);
    end
    while (exp_dq.size() > 0) begin
      e = exp_dq.pop_front();
      o = obs_dq.size() > 0 ? obs_dq.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL prog_access w=%0d: got %h expected %h", w, o, e);
      end
    end
    checks++;
    if (obs_dq.size() != 0 || unstable != 0) begin
      failures++;
      $display("FAIL prog_extra w=%0d: extra accesses=%0d unstable=%0d expected 0/0", w, obs_dq.size(), unstable);
    end
  endtask

  task automatic test_branch;
    int cyc, n;
    int rc[6];
    bit ok;
    logic [31:0] e, o;
    clear_mem();
    imem[0] = enc_i(8, 0, 1, 1);
    imem[1] = enc_i(8, 0, 0, 5);
    imem[2] = enc_i(4, 0, 0, -1);
    exp_fq = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
    wait_cfg = 0;
    do_reset();
    cyc = 0;
    n = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (retire_o) begin
        rc[n] = cyc;
        n++;
      end
    end
    checks++;
    if (n != 6 || rc[3] - rc[2] != 3 || rc[4] - rc[3] != 3 || rc[5] - rc[4] != 3) begin
      failures++;
      $display("FAIL beq_period: retires=%0d gaps=%0d,%0d,%0d expected 3,3,3", n, rc[3] - rc[2], rc[4] - rc[3], rc[5] - rc[4]);
    end
    checks++;
    if (dut.rf_q[0] !== 32'h0 || dut.rf_q[1] !== 32'h1) begin
      failures++;
      $display("FAIL zero_reg: r0=%h r1=%h expected 0/1", dut.rf_q[0], dut.rf_q[1]);
    end
    while (exp_fq.size() > 0) begin
      e = exp_fq.pop_front();
      o = obs_fq.size() > 0 ? obs_fq.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL beq_fetch: got %h expected %h", o, e);
      end
    end
    clear_mem();
    imem[0] = enc_i(8, 0, 0, 0);
    imem[1] = enc_i(8, 0, 0, 0);
    imem[2] = enc_i(5, 0, 0, 7);
    exp_fq = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    wait_halt(100, ok);
    checks++;
    if (!ok || pc_o !== 32'h10) begin
      failures++;
      $display("FAIL bne_halt: halted=%b pc=%h expected 1 pc=00000010", halted_o, pc_o);
    end
    while (exp_fq.size() > 0) begin
      e = exp_fq.pop_front();
      o = obs_fq.size() > 0 ? obs_fq.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bne_fetch: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_alu;
    bit ok;
    clear_mem();
    imem[0]  = {6'd2, 26'd2};
    imem[2]  = enc_i(15, 0, 5, 16'h1234);
    imem[3]  = enc_i(13, 5, 5, 16'h8000);
    imem[4]  = enc_i(8, 0, 6, -1);
    imem[5]  = enc_r(6, 0, 7, 42);
    imem[6]  = enc_i(10, 0, 8, -1);
    imem[7]  = enc_r(0, 6, 9, 34);
    imem[8]  = enc_r(5, 6, 10, 36);
    imem[9]  = enc_r(0, 6, 11, 37);
    wait_cfg = 1;
    do_reset();
    wait_halt(300, ok);
    checks++;
    if (!ok || pc_o !== 32'h2C) begin
      failures++;
      $display("FAIL alu_halt: halted=%b pc=%h expected 1 pc=0000002c", halted_o, pc_o);
    end
    checks++;
    if (dut.rf_q[5] !== 32'h1234_8000 || dut.rf_q[6] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL alu_lui_ori: r5=%h r6=%h expected 12348000/ffffffff", dut.rf_q[5], dut.rf_q[6]);
    end
    checks++;
    if (dut.rf_q[7] !== 32'd1 || dut.rf_q[8] !== 32'd0) begin
      failures++;
      $display("FAIL alu_slt: r7=%h r8=%h expected 1/0", dut.rf_q[7], dut.rf_q[8]);
    end
    checks++;
    if (dut.rf_q[9] !== 32'd1 || dut.rf_q[10] !== 32'h1234_8000 || dut.rf_q[11] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL alu_logic: r9=%h r10=%h r11=%h expected 1/12348000/ffffffff", dut.rf_q[9], dut.rf_q[10], dut.rf_q[11]);
    end
  endtask

  task automatic test_misaligned;
    bit ok;
    clear_mem();
    imem[0] = enc_i(35, 0, 1, 2);
    wait_cfg = 0;
    do_reset();
    wait_halt(50, ok);
    checks++;
    if (!ok || halted_o !== 1'b1 || pc_o !== 32'h4) begin
      failures++;
      $display("FAIL misaligned_halt: halted=%b pc=%h expected 1 pc=00000004", halted_o, pc_o);
    end
    req_cnt = 0;
    repeat (20) @(negedge clk_i);
    #1;
    checks++;
    if (req_cnt != 0 || obs_dq.size() != 0 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_quiet: reqs=%0d data accesses=%0d expected 0/0", req_cnt, obs_dq.size());
    end
    checks++;
    if (dut.rf_q[1] !== 32'h0 || state_o !== 3'd7) begin
      failures++;
      $display("FAIL misaligned_state: r1=%h state=%0d expected 0/7", dut.rf_q[1], state_o);
    end
  endtask

  task automatic test_mul;
    bit ok;
    logic [31:0] exp_r3, exp_pc;
`ifdef MULTI_CYCLE_CPU_MUL_EN
    exp_r3 = 32'hFFFF_FFD6;
    exp_pc = 32'h14;
`else
    exp_r3 = 32'h0;
    exp_pc = 32'h10;
`endif
    clear_mem();
    imem[0] = enc_i(8, 0, 1, 7);
    imem[1] = enc_i(8, 0, 2, -6);
    imem[3] = 32'h0022_1818;
    imem[2] = enc_i(8, 0, 0, 0);
    wait_cfg = 0;
    do_reset();
    wait_halt(100, ok);
    checks++;
    if (!ok || pc_o !== exp_pc) begin
      failures++;
      $display("FAIL mul_halt: halted=%b pc=%h expected 1 pc=%h", halted_o, pc_o, exp_pc);
    end
    checks++;
    if (dut.rf_q[3] !== exp_r3) begin
      failures++;
      $display("FAIL mul_result: r3=%h expected %h", dut.rf_q[3], exp_r3);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program(0);
    test_program(3);
    test_branch();
    test_alu();
    test_misaligned();
    test_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
